// File: rtl/rot_reset_ctrl_pkg.sv
// Shared types and widths for the RoT reset controller.
// FSM state encoding, field widths, event record width helper.
package rot_reset_ctrl_pkg;

  localparam int SEQ_W = 8;
  localparam int PC_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_KILL    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Event record: {src, pc, seq, retry}
  function automatic int rec_w(input int nsrc);
    return nsrc + PC_W + SEQ_W + 1;
  endfunction

endpackage

// File: rtl/rot_reset_ctrl_if.sv
// Kill event record port (valid/ready) to attestation logic.
// master: controller drives record; slave: consumer drives ready.
interface rot_reset_ctrl_if #(
  parameter int NSRC = 2
) ();
  import rot_reset_ctrl_pkg::*;

  logic             evt_valid;
  logic             evt_ready;
  logic [NSRC-1:0]  evt_src;
  logic [PC_W-1:0]  evt_pc;
  logic [SEQ_W-1:0] evt_seq;
  logic             evt_retry;

  modport master (
    output evt_valid,
    output evt_src,
    output evt_pc,
    output evt_seq,
    output evt_retry,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_src,
    input  evt_pc,
    input  evt_seq,
    input  evt_retry,
    output evt_ready
  );
endinterface

// File: rtl/rot_reset_ctrl_slot.sv
// Single-entry valid/ready holding register with sticky overflow.
// Ports: clk, rst, i_cap/i_data (capture), i_ready, o_valid, o_data, o_ovf.
module rot_reset_ctrl_slot #(
  parameter int W = 27
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_cap,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_ovf
);

  logic         r_valid;
  logic         r_ovf;
  logic [W-1:0] r_data;
  logic         w_load;

  // A capture lands if the slot is empty or drains this same edge
  assign w_load = i_cap && (!r_valid || i_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_cap && !w_load) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/rot_reset_ctrl.sv
// Monitor-driven MCU reset controller: stretched kills, timeout re-kill, event log.
// Ports: clk, rst, i_req, i_pc, o_cpu_reset, evt (record port), o_evt_overflow, o_kill_cnt.
module rot_reset_ctrl
  import rot_reset_ctrl_pkg::*;
#(
  parameter int NSRC       = 2,
  parameter int RST_CYCLES = 8,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   i_req,
  input  logic [PC_W-1:0]   i_pc,
  output logic              o_cpu_reset,
  rot_reset_ctrl_if.master  evt,
  output logic              o_evt_overflow,
  output logic [CNT_W-1:0]  o_kill_cnt
);

  localparam int CMAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
  localparam int CW   = $clog2(CMAX);
  localparam int RW   = rec_w(NSRC);

  state_t             r_state;
  state_t             w_state_nx;
  logic [CW-1:0]      r_cnt;
  logic [CW-1:0]      w_cnt_nx;
  logic               r_cpu_reset;
  logic               w_rst_nx;
  logic [SEQ_W-1:0]   r_seq;
  logic [CNT_W-1:0]   r_kill_cnt;
  logic               w_req_any;
  logic               w_kill;
  logic               w_retry;
  logic [RW-1:0]      w_rec_d;
  logic [RW-1:0]      w_rec_q;

  assign w_req_any = |i_req;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cpu_reset <= 1'b0;
      r_seq       <= '0;
      r_kill_cnt  <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_cpu_reset <= w_rst_nx;
      if (w_kill) begin
        r_seq <= r_seq + 1'b1;
        if (~&r_kill_cnt) begin
          r_kill_cnt <= r_kill_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_rst_nx   = r_cpu_reset;
    w_kill     = 1'b0;
    w_retry    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_kill = 1'b1;
        end
      end
      ST_KILL: begin
        if (r_cnt == '0) begin
          w_state_nx = ST_RELEASE;
          w_rst_nx   = 1'b0;
          w_cnt_nx   = CW'(TIMEOUT - 1);
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      ST_RELEASE: begin
        // Dropped request wins over an expiring timer
        if (!w_req_any) begin
          w_state_nx = ST_IDLE;
        end else if (r_cnt == '0) begin
          w_kill  = 1'b1;
          w_retry = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nx = ST_IDLE;
        w_rst_nx   = 1'b0;
      end
    endcase
    if (w_kill) begin
      w_state_nx = ST_KILL;
      w_rst_nx   = 1'b1;
      w_cnt_nx   = CW'(RST_CYCLES - 1);
    end
  end

  assign w_rec_d = {i_req, i_pc, r_seq, w_retry};

  rot_reset_ctrl_slot #(
    .W (RW)
  ) u_slot (
    .clk     (clk),
    .rst     (rst),
    .i_cap   (w_kill),
    .i_data  (w_rec_d),
    .i_ready (evt.evt_ready),
    .o_valid (evt.evt_valid),
    .o_data  (w_rec_q),
    .o_ovf   (o_evt_overflow)
  );

  assign evt.evt_retry = w_rec_q[0];
  assign evt.evt_seq   = w_rec_q[SEQ_W:1];
  assign evt.evt_pc    = w_rec_q[PC_W+SEQ_W:SEQ_W+1];
  assign evt.evt_src   = w_rec_q[RW-1:RW-NSRC];

  assign o_cpu_reset = r_cpu_reset;
  assign o_kill_cnt  = r_kill_cnt;

endmodule

// File: tb/tb_rot_reset_ctrl.sv
// Scoreboard bench for rot_reset_ctrl against a kill-timeline model.
// Second instance uses a 2-bit kill counter to reach saturation quickly.
module tb_rot_reset_ctrl;
  import rot_reset_ctrl_pkg::*;

  localparam int NSRC = 2;
  localparam int RSTC = 8;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = '0;
  logic [15:0] pc = '0;
  logic        ready = 1'b0;
  logic        cpu_reset, ovf;
  logic        cpu_reset2, ovf2;
  logic [15:0] kcnt;
  logic [1:0]  kcnt2;

  rot_reset_ctrl_if #(.NSRC(NSRC)) ev ();
  rot_reset_ctrl_if #(.NSRC(NSRC)) ev2 ();

  assign ev.evt_ready  = ready;
  assign ev2.evt_ready = ready;

  rot_reset_ctrl #(
    .NSRC(NSRC), .RST_CYCLES(RSTC), .TIMEOUT(TMO), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_pc(pc),
    .o_cpu_reset(cpu_reset), .evt(ev.master),
    .o_evt_overflow(ovf), .o_kill_cnt(kcnt)
  );

  rot_reset_ctrl #(
    .NSRC(NSRC), .RST_CYCLES(RSTC), .TIMEOUT(TMO), .CNT_W(2)
  ) dut2 (
    .clk(clk), .rst(rst), .i_req(req), .i_pc(pc),
    .o_cpu_reset(cpu_reset2), .evt(ev2.master),
    .o_evt_overflow(ovf2), .o_kill_cnt(kcnt2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  src;
    logic [15:0] pc;
    logic [7:0]  seq;
    logic        retry;
  } rec_t;

  // Model: reset-hold cycles left, grace window age, slot, kill total
  int   hold, since, kills;
  bit   rel, m_valid, m_ovf, armed;
  rec_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t act=%h exp=%h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step(input logic [1:0] rq, input logic [15:0] p,
                            input logic rd, input logic rs);
    bit   kill, retry, hs;
    rec_t r;
    if (rs) begin
      hold = 0; since = 0; kills = 0;
      rel = 0; m_valid = 0; m_ovf = 0;
      q.delete();
      return;
    end
    kill = 0; retry = 0;
    hs = m_valid && rd;
    if (hold > 0) begin
      hold--;
      if (hold == 0) begin
        rel = 1; since = 0;
      end
    end else if (rel) begin
      if (rq == 2'b00) rel = 0;
      else if (since == TMO - 1) begin kill = 1; retry = 1; end
      else since++;
    end else if (rq != 2'b00) begin
      kill = 1;
    end
    if (kill) begin
      hold = RSTC; rel = 0;
      r.src = rq; r.pc = p; r.seq = 8'(kills % 256); r.retry = retry;
      if (!m_valid || hs) begin
        q.push_back(r); m_valid = 1;
      end else begin
        m_ovf = 1;
      end
      kills++;
    end else if (hs) begin
      m_valid = 0;
    end
  endtask

  task automatic tick(input logic [1:0] rq, input logic [15:0] p,
                      input logic rd, input logic rs);
    @(posedge clk);
    #1;
    if (armed) begin
      chk("cpu_reset", 32'(cpu_reset), 32'(hold > 0));
      chk("evt_valid", 32'(ev.evt_valid), 32'(m_valid));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("kill_cnt", 32'(kcnt), 32'((kills > 65535) ? 65535 : kills));
      chk("kill_cnt_sat2", 32'(kcnt2), 32'((kills > 3) ? 3 : kills));
      chk("cpu_reset2", 32'(cpu_reset2), 32'(hold > 0));
    end
    req = rq; pc = p; ready = rd; rst = rs;
    model_step(rq, p, rd, rs);
    if (rs) armed = 1;
  endtask

  task automatic run(input int n, input logic [1:0] rq,
                     input logic [15:0] p, input logic rd);
    for (int i = 0; i < n; i++) tick(rq, p, rd, 1'b0);
  endtask

  // Monitor: a handshake is due at the next edge, retire the front record
  always @(negedge clk) begin
    rec_t e;
    if (armed && !rst && ev.evt_valid === 1'b1 && ready === 1'b1) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL evt_unexpected t=%0t act=seq%0d exp=none",
                 $time, ev.evt_seq);
      end else begin
        e = q.pop_front();
        chk("evt_src", 32'(ev.evt_src), 32'(e.src));
        chk("evt_pc", 32'(ev.evt_pc), 32'(e.pc));
        chk("evt_seq", 32'(ev.evt_seq), 32'(e.seq));
        chk("evt_retry", 32'(ev.evt_retry), 32'(e.retry));
      end
    end
  end

  initial begin
    int dur;
    logic [1:0] r;
    armed = 0;
    for (int i = 0; i < 3; i++) tick(2'b00, 16'h0, 1'b1, 1'b1);
    // single kill
    run(3, 2'b01, 16'hE01C, 1'b1);
    run(20, 2'b00, 16'h0, 1'b1);
    // held request -> timeout re-kill
    run(110, 2'b10, 16'h1234, 1'b1);
    run(20, 2'b00, 16'h0, 1'b1);
    // consumer stalled across two kills
    run(1, 2'b01, 16'hA001, 1'b0);
    run(20, 2'b00, 16'h0, 1'b0);
    run(1, 2'b11, 16'hA002, 1'b0);
    run(20, 2'b00, 16'h0, 1'b0);
    run(2, 2'b00, 16'h0, 1'b1);
    run(1, 2'b10, 16'hA003, 1'b1);
    run(20, 2'b00, 16'h0, 1'b1);
    // pulse during KILL
    run(1, 2'b01, 16'hB000, 1'b1);
    run(3, 2'b00, 16'h0, 1'b1);
    run(1, 2'b10, 16'hB001, 1'b1);
    run(20, 2'b00, 16'h0, 1'b1);
    // reset mid-KILL
    run(1, 2'b01, 16'hC000, 1'b0);
    run(3, 2'b00, 16'h0, 1'b0);
    tick(2'b00, 16'h0, 1'b0, 1'b1);
    run(5, 2'b00, 16'h0, 1'b1);
    // power-on kill: request already high when reset drops
    tick(2'b11, 16'hD000, 1'b1, 1'b1);
    run(4, 2'b11, 16'hD000, 1'b1);
    run(15, 2'b00, 16'h0, 1'b1);
    // random traffic: seq wrap, saturation, overflow
    for (int k = 0; k < 900; k++) begin
      r = ($urandom_range(0, 1) != 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      dur = int'($urandom_range(1, 12));
      for (int j = 0; j < dur; j++) begin
        tick(r, 16'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0);
      end
    end
    run(15, 2'b00, 16'h0, 1'b1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
